serial_twos_comp_ctrl: RTL and testbench

Word-level sequencer for the team's bit-serial two's complementer. It accepts a parallel W-bit word over a valid/ready handshake and clears the serial unit. It then streams the word LSB-first into the serial unit, reassembles the returned serial bits into a parallel result, and presents that result with an overflow flag over a second valid/ready handshake. It sits between a parallel producer/consumer pair and one shared serial complementer instance.

---
 rtl/serial_twos_comp_ctrl.sv | 120 ++++++++++++
 tb/tb_serial_twos_comp_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_twos_comp_ctrl.sv
// Word-level sequencer for the bit-serial two's complementer: it takes a parallel word,
// streams it LSB-first through the serial unit and returns the reassembled result.
module serial_twos_comp_ctrl #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic         t_clock,
    input  logic         r,
    // Both ports use the same handshake rule: a transfer happens at a rising edge
    // where valid && ready are both high. Valid never depends combinationally on ready.
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_ovf,
    output logic         ser_clr,
    output logic         ser_x,
    input  logic         ser_y,
    output logic         busy,
    output logic [1:0]   dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q;
    logic [W-1:0]   shift_q;
    logic [W-1:0]   hold_q;
    logic [W-1:0]   result_q;
    logic [W-1:0]   result_d;
    logic [W-1:0]   out_data_q;
    logic [CW-1:0]  bitcnt_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic           out_ovf_q;
    logic           ser_clr_q;
    logic           ser_x_q;
    logic           busy_q;
    logic           last_bit;

    // ser_y is combinational on ser_x, so the bit returned this cycle enters at the MSB.
    assign result_d = {ser_y, result_q[W-1:1]};
    assign last_bit = (bitcnt_q == CW'(W - 1));

    always_ff @(posedge t_clock or negedge r) begin
        if (!r) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            result_q    <= '0;
            out_data_q  <= '0;
            bitcnt_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            ser_clr_q   <= 1'b0;
            ser_x_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        shift_q    <= in_data;
                        hold_q     <= in_data;
                        in_ready_q <= 1'b0;
                        ser_clr_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= CLR;
                    end
                end
                CLR: begin
                    ser_clr_q <= 1'b0;
                    ser_x_q   <= shift_q[0];
                    bitcnt_q  <= '0;
                    state_q   <= SHIFT;
                end
                SHIFT: begin
                    result_q <= result_d;
                    shift_q  <= shift_q >> 1;
                    bitcnt_q <= bitcnt_q + CW'(1);
                    if (last_bit) begin
                        ser_x_q     <= 1'b0;
                        out_data_q  <= result_d;
                        // Only the most negative value maps onto itself with a non-zero input.
                        out_ovf_q   <= (ser_y == hold_q[W-1]) && (hold_q != '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        ser_x_q <= shift_q[1];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_ovf     = out_ovf_q;
    assign ser_clr     = ser_clr_q;
    assign ser_x       = ser_x_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_twos_comp_ctrl.sv
// Directed bench for serial_twos_comp_ctrl (W=8) with a behavioural serial complementer.
module tb_serial_twos_comp_ctrl;

    logic       t_clock;
    logic       r;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf;
    logic       ser_clr;
    logic       ser_x;
    logic       ser_y;
    logic       busy;
    logic [1:0] dbg_state;
    logic       seen_q;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Clock and reset
    initial t_clock = 1'b0;
    always #5 t_clock = ~t_clock;

    // Serial unit model: output is input XOR "a 1 has been seen before this bit".
    always @(posedge t_clock or negedge r) begin
        if (!r)          seen_q <= 1'b0;
        else if (ser_clr) seen_q <= 1'b0;
        else             seen_q <= seen_q | ser_x;
    end
    assign ser_y = ser_x ^ seen_q;

    serial_twos_comp_ctrl #(.W(8), .CW(4)) dut (
        .t_clock     (t_clock),
        .r           (r),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ovf     (out_ovf),
        .ser_clr     (ser_clr),
        .ser_x       (ser_x),
        .ser_y       (ser_y),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // Driver: offers one word, returns in the first cycle out_valid is seen.
    // Cycle 0 is the cycle in which the handshake is presented.
    task automatic run_word(input logic [7:0] d, input logic rdy,
                            output logic [7:0] got, output logic got_ovf,
                            output int lat, output logic [7:0] sx,
                            output int clr_cnt, output bit ok);
        int t;
        ok = 1'b1; got = '0; got_ovf = 1'b0; lat = -1; sx = '0; clr_cnt = 0;
        in_data = d; in_valid = 1'b1; out_ready = rdy;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge t_clock);
            t++;
        end
        if (!in_ready) begin
            ok = 1'b0;
            in_valid = 1'b0;
            return;
        end
        @(negedge t_clock);
        in_valid = 1'b0;
        t = 1;
        while (!out_valid && t < 50) begin
            if (ser_clr) clr_cnt++;
            if (dbg_state == ST_SHIFT) sx = {ser_x, sx[7:1]};
            @(negedge t_clock);
            t++;
        end
        if (!out_valid) begin
            ok = 1'b0;
            return;
        end
        lat = t; got = out_data; got_ovf = out_ovf;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge t_clock);
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        r = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge t_clock);
        obs = {in_ready, out_valid, out_ovf, ser_clr, ser_x, busy, dbg_state, out_data};
        n_checks++;
        if (obs !== 16'h8000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 16'h8000);
        end
        r = 1'b1;
        repeat (2) @(negedge t_clock);
        obs = {in_ready, out_valid, out_ovf, ser_clr, ser_x, busy, dbg_state, out_data};
        n_checks++;
        if (obs !== 16'h8000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h expected %h", obs, 16'h8000);
        end
    endtask

    task automatic test_basic();
        logic [7:0] got, sx;
        logic ovf;
        int lat, clr_cnt;
        bit ok;
        run_word(8'h05, 1'b1, got, ovf, lat, sx, clr_cnt, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL basic_timeout: got ok=%0d expected ok=1", ok);
        end
        n_checks++;
        if ({got, ovf} !== {8'hFB, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_result: got %h/%b expected fb/0", got, ovf);
        end
        n_checks++;
        if (lat !== 10) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected 10", lat);
        end
        n_checks++;
        if (sx !== 8'h05) begin
            n_fail++;
            $display("FAIL basic_ser_x_stream: got %h expected 05", sx);
        end
        n_checks++;
        if (clr_cnt !== 1) begin
            n_fail++;
            $display("FAIL basic_clr_pulses: got %0d expected 1", clr_cnt);
        end
        n_checks++;
        if ({busy, in_ready, ser_x, ser_clr} !== 4'b1000) begin
            n_fail++;
            $display("FAIL basic_done_flags: got %b expected 1000", {busy, in_ready, ser_x, ser_clr});
        end
        release_out();
        n_checks++;
        if ({dbg_state, out_valid, in_ready, busy} !== {ST_IDLE, 3'b010}) begin
            n_fail++;
            $display("FAIL basic_back_to_idle: got %b expected 00010", {dbg_state, out_valid, in_ready, busy});
        end
    endtask

    task automatic test_vectors();
        logic [7:0] vin[4];
        logic [7:0] vexp[4];
        logic       vovf[4];
        logic [7:0] got, sx;
        logic ovf;
        int lat, clr_cnt;
        bit ok;
        vin[0] = 8'h00; vexp[0] = 8'h00; vovf[0] = 1'b0;
        vin[1] = 8'h01; vexp[1] = 8'hFF; vovf[1] = 1'b0;
        vin[2] = 8'h80; vexp[2] = 8'h80; vovf[2] = 1'b1;
        vin[3] = 8'h7F; vexp[3] = 8'h81; vovf[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_word(vin[i], 1'b1, got, ovf, lat, sx, clr_cnt, ok);
            n_checks++;
            if (!ok || got !== vexp[i]) begin
                n_fail++;
                $display("FAIL vec_data_%h: got %h expected %h (ok=%0d)", vin[i], got, vexp[i], ok);
            end
            n_checks++;
            if (ovf !== vovf[i]) begin
                n_fail++;
                $display("FAIL vec_ovf_%h: got %b expected %b", vin[i], ovf, vovf[i]);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] got, sx;
        logic ovf;
        int lat, clr_cnt;
        bit ok;
        run_word(8'h22, 1'b0, got, ovf, lat, sx, clr_cnt, ok);
        n_checks++;
        if (!ok || {got, ovf} !== {8'hDE, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_result: got %h/%b expected de/0 (ok=%0d)", got, ovf, ok);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge t_clock);
            n_checks++;
            if ({out_valid, in_ready, out_ovf, dbg_state, out_data} !== {3'b100, ST_DONE, 8'hDE}) begin
                n_fail++;
                $display("FAIL bp_hold_cycle%0d: got %b expected 10011%b", c,
                         {out_valid, in_ready, out_ovf, dbg_state, out_data}, 8'hDE);
            end
        end
        release_out();
        n_checks++;
        if ({dbg_state, out_valid, in_ready} !== {ST_IDLE, 2'b01}) begin
            n_fail++;
            $display("FAIL bp_release: got %b expected 0001", {dbg_state, out_valid, in_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [7:0] e;
        int acc_cyc[2];
        int acc_n, outs, clr;
        exp_q = {8'hFD, 8'hF0};
        acc_n = 0; outs = 0; clr = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        in_data = 8'h03; in_valid = 1'b1; out_ready = 1'b1;
        for (int t = 0; t < 80 && outs < 2; t++) begin
            if (ser_clr) clr++;
            if (in_valid && in_ready && acc_n < 2) begin
                acc_cyc[acc_n] = t;
                acc_n++;
            end
            if (out_valid) begin
                outs++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra_output: got %h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_fail++;
                        $display("FAIL b2b_data: got %h expected %h", out_data, e);
                    end
                end
            end
            @(negedge t_clock);
            if (acc_n == 1) in_data = 8'h10;
            if (acc_n == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        n_checks++;
        if (outs !== 2 || acc_n !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: got outs=%0d acc=%0d expected 2/2", outs, acc_n);
        end
        n_checks++;
        if (acc_cyc[1] - acc_cyc[0] !== 11) begin
            n_fail++;
            $display("FAIL b2b_period: got %0d expected 11", acc_cyc[1] - acc_cyc[0]);
        end
        n_checks++;
        if (clr !== 2) begin
            n_fail++;
            $display("FAIL b2b_clr_pulses: got %0d expected 2", clr);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [15:0] obs;
        logic [7:0] got, sx;
        logic ovf;
        int lat, clr_cnt, k;
        bit ok;
        in_data = 8'h2C; in_valid = 1'b1; out_ready = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge t_clock);
            k++;
        end
        @(negedge t_clock);
        in_valid = 1'b0;
        k = 0;
        while (dbg_state != ST_SHIFT && k < 10) begin
            @(negedge t_clock);
            k++;
        end
        repeat (4) @(negedge t_clock);
        n_checks++;
        if (dbg_state !== ST_SHIFT) begin
            n_fail++;
            $display("FAIL rst_mid_in_shift: got %b expected %b", dbg_state, ST_SHIFT);
        end
        r = 1'b0;
        #1;
        obs = {in_ready, out_valid, out_ovf, ser_clr, ser_x, busy, dbg_state, out_data};
        n_checks++;
        if (obs !== 16'h8000) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %h expected %h", obs, 16'h8000);
        end
        @(negedge t_clock);
        r = 1'b1;
        @(negedge t_clock);
        run_word(8'h2C, 1'b1, got, ovf, lat, sx, clr_cnt, ok);
        n_checks++;
        if (!ok || {got, ovf} !== {8'hD4, 1'b0} || lat !== 10) begin
            n_fail++;
            $display("FAIL rst_mid_rerun: got %h/%b lat=%0d expected d4/0 lat=10 (ok=%0d)", got, ovf, lat, ok);
        end
        release_out();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        repeat (2) @(negedge t_clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
